// File: rtl/ksa_serial_adder.sv
// ksa_serial_adder
//   Multi-cycle WIDTH-bit adder built around one 4-bit Kogge-Stone slice (KSA).
//   Operands are accepted over a valid/ready handshake and added one nibble per
//   cycle, LSB nibble first. The slice carry is chained through a register. The
//   result is returned over a second valid/ready handshake.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : WIDTH-bit operands and carry-in
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : registered sum and carry-out of the top slice
//   ovf                 : signed overflow, only with KSA_SERIAL_OVF_EN defined
//
// Build option: define KSA_SERIAL_OVF_EN to add the ovf output.
module ksa_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef KSA_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic            carry, cout_reg;
    logic [IW-1:0]   idx;
    logic            last;
    logic [3:0]      ksa_a, ksa_b;
    logic            ksa_cin;
    logic [4:0]      ksa_s;

    assign last = (idx == LAST);

    // Operand mux: zeros outside RUN so the slice never sees X.
    always_comb begin
        ksa_a   = '0;
        ksa_b   = '0;
        ksa_cin = 1'b0;
        if (state == RUN) begin
            ksa_a   = a_reg[{idx, 2'b00} +: 4];
            ksa_b   = b_reg[{idx, 2'b00} +: 4];
            ksa_cin = carry;
        end
    end

    KSA u_ksa (
        .A   (ksa_a),
        .B   (ksa_b),
        .Cin (ksa_cin),
        .S   (ksa_s)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                a_reg <= a;
                b_reg <= b;
                carry <= cin;
                idx   <= '0;
            end else if (state == RUN) begin
                sum_reg[{idx, 2'b00} +: 4] <= ksa_s[3:0];
                carry <= ksa_s[4];
                if (last) cout_reg <= ksa_s[4];
                else      idx      <= idx + 1'b1;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

`ifdef KSA_SERIAL_OVF_EN
    logic ovf_reg;
    // Carry into the MSB is recovered from the MSB sum bit; overflow is that
    // carry differing from the carry out of the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_reg <= 1'b0;
        else if (state == RUN && last)
            ovf_reg <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ ksa_s[3]) ^ ksa_s[4];
    end
    assign ovf = ovf_reg;
`endif
endmodule

// 4-bit Kogge-Stone adder slice. S[4] is the carry out.
module KSA (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [4:0] S
);
    logic [3:0] g, p, g1, p1, g2;
    logic [4:0] c;

    always_comb begin
        p = A ^ B;
        g = A & B;
        // Fold carry-in into bit 0 generate so the prefix tree needs no extra level.
        g[0] = g[0] | (p[0] & Cin);
        g1 = g;
        p1 = p;
        for (int i = 1; i < 4; i++) begin
            g1[i] = g[i] | (p[i] & g[i-1]);
            p1[i] = p[i] & p[i-1];
        end
        g2 = g1;
        for (int i = 2; i < 4; i++)
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
        c[0] = Cin;
        for (int i = 0; i < 4; i++)
            c[i+1] = g2[i];
        S[3:0] = p ^ c[3:0];
        S[4]   = c[4];
    end
endmodule

// File: tb/tb_ksa_serial_adder.sv
module tb_ksa_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // 16-bit instance
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [15:0] a, b, sum;
`ifdef KSA_SERIAL_OVF_EN
    logic        ovf;
`endif

    ksa_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum),
`ifdef KSA_SERIAL_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout));

    // 4-bit instance
    logic       rst4_n, in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef KSA_SERIAL_OVF_EN
    logic       ovf4;
`endif

    ksa_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4),
`ifdef KSA_SERIAL_OVF_EN
        .ovf(ovf4),
`endif
        .cout(cout4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 16-bit add: reference is plain integer arithmetic.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input bit inject, input bit hold);
        logic [16:0] ref_v;
        logic [15:0] s_hold;
        int          lat;
        int          w;
        ref_v = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        out_ready = hold ? 1'b0 : 1'b1;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            if (inject && lat == 1) begin
                in_valid = 1'b1; a = ~ta; b = ta; cin = ~tc;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end
        check("latency", lat, 4);
        check("sum", {16'd0, sum}, {16'd0, ref_v[15:0]});
        check("cout", {31'd0, cout}, {31'd0, ref_v[16]});
`ifdef KSA_SERIAL_OVF_EN
        check("ovf", {31'd0, ovf},
              {31'd0, (ta[15] == tb_[15]) && (ref_v[15] != ta[15])});
`endif
        if (hold) begin
            s_hold = ref_v[15:0];
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_sum", {15'd0, cout, sum}, {15'd0, ref_v[16], s_hold});
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_sum_kept", {16'd0, sum}, {16'd0, ref_v[15:0]});
    endtask

    initial begin
        int lat;
        logic [4:0] ref4;
        rst_n = 1'b0; rst4_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk); rst_n = 1'b1; rst4_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run16(16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0);
        run16(16'hA5A5, 16'h5A5B, 1'b1, 1'b0, 1'b1);
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run16(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run16(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);

        // Random
        for (int r = 0; r < 40; r++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, (r % 10) == 3);

        // WIDTH=4 exhaustive
        for (int i = 0; i < 512; i++) begin
            a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8);
            ref4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            lat = 0;
            while (!in_ready4 && lat < 5) begin @(posedge clk); #1; lat++; end
            in_valid4 = 1'b1;
            @(posedge clk); #1;
            in_valid4 = 1'b0;
            lat = 0;
            while (!out_valid4 && lat < 5) begin @(posedge clk); #1; lat++; end
            check("w4_latency", lat, 1);
            check("w4_result", {27'd0, cout4, sum4}, {27'd0, ref4});
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ksa_serial_adder.md
# ksa_serial_adder

Multi-cycle wide adder that sits directly upstream of the 4-bit Kogge-Stone slice `KSA` and drives it. It accepts a WIDTH-bit operand pair over a valid/ready handshake and feeds one nibble per cycle into a single `KSA` instance, LSB nibble first. It chains the slice carry through a register and returns the assembled WIDTH-bit sum plus carry-out over a second valid/ready handshake.

## Interface
- `WIDTH`, 16: operand width in bits; a multiple of 4 and at least 4; N = WIDTH/4 slices.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand pair and `cin` are valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in to slice 0.
- `out_valid` output 1: `sum`/`cout` are valid.
- `out_ready` input 1: consumer takes the result.
- `sum` output WIDTH: registered sum, (a+b+cin) mod 2^WIDTH.
- `cout` output 1: registered carry-out of the top slice.
- `ovf` output 1: signed overflow flag; present only when `KSA_SERIAL_OVF_EN` is defined.

## Operation
- FSM states and transitions:
  - IDLE: `in_ready`=1. Moves to RUN when `in_valid & in_ready`.
  - RUN: processes one slice per cycle. Moves to DONE after slice N-1 is registered.
  - DONE: `out_valid`=1. Moves to IDLE when `out_ready` is high at the clock edge.
- Acceptance edge:
  - Capture `a` and `b` into operand registers.
  - Load the carry register with `cin`.
  - Clear the slice index to 0.
- RUN, each cycle with slice index i:
  - `KSA.A` = a_reg[4i+3:4i], `KSA.B` = b_reg[4i+3:4i], `KSA.Cin` = carry register.
  - On the edge: sum_reg[4i+3:4i] <= S[3:0], carry <= S[4], i <= i+1.
  - On the final slice (i = N-1), `cout` <= S[4] and the state moves to DONE.
- The index counter is $clog2(N) bits (minimum 1). It is compared against N-1; it does not wrap.
- `in_valid` is ignored in RUN and DONE, and the operand registers do not change. The upstream producer holds its data until it sees `in_ready`.
- `sum` and `cout` are stable from the DONE entry edge until the output handshake. After the handshake they keep their last values until the next result overwrites them.
- In IDLE the `KSA` inputs are driven to 0, never X.
- Reset, at any time including mid-RUN:
  - State returns to IDLE.
  - `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, carry register=0, index=0.
  - Any in-flight operation is discarded and produces no output.

## Timing
- Accept at edge T0. Slices are registered at edges T1..TN. `out_valid` rises after TN, so latency is N cycles from acceptance to `out_valid`.
- Output handshake at edge Tk means `in_ready` is high from Tk on. The next acceptance can happen no earlier than edge Tk+1.
- Throughput with `out_ready` held at 1 is one result per N+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only. Neither depends combinationally on `in_valid` or `out_ready`.
- The combinational path is operand mux -> `KSA` -> sum/carry registers. No other logic is placed in series with the slice.

## Configuration
- `KSA_SERIAL_OVF_EN` defined:
  - Adds the `ovf` output port.
  - On the final slice, `ovf` <= (carry into bit WIDTH-1) XOR S[4]. The carry into bit WIDTH-1 is derived as a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ S[3].
  - `ovf` is registered alongside `cout` and resets to 0.
- `KSA_SERIAL_OVF_EN` not defined: no `ovf` port and no associated logic; all other behaviour is identical.

## Test plan
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, `out_ready`=1 -> `out_valid` exactly 4 cycles after acceptance; `sum`=0x0000, `cout`=1.
- WIDTH=16, a=0x1234, b=0x4321, cin=1 -> `sum`=0x5556, `cout`=0. A second `in_valid` pulse with different data during RUN is ignored and the result is unchanged.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` -> `sum`, `cout` and `out_valid` stay stable and `in_ready` stays 0; the handshake on the 6th cycle returns the block to IDLE.
- Reset: assert `rst_n`=0 in the 2nd RUN cycle -> `out_valid`=0, `sum`=0 and `in_ready`=1 immediately, without waiting for a clock edge. A new add of 0x0003+0x0004 then yields `sum`=0x0007.
- WIDTH=4, exhaustive over all 512 (a, b, cin) combinations -> {`cout`,`sum`} equals a+b+cin, latency 1 cycle, no X on any output.
- With `KSA_SERIAL_OVF_EN` defined and WIDTH=16:
  - 0x7FFF+0x0001 -> `sum`=0x8000, `ovf`=1, `cout`=0.
  - 0xFFFF+0x0001 -> `ovf`=0, `cout`=1.
